// File: rtl/mem_arbiter_pkg.sv
// Shared types and encodings for the byte-serial memory arbiter.
package mem_arbiter_pkg;

  // Transfer sequencer states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Which requester owns the transfer in flight
  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_MEM = 1'b1
  } owner_e;

  // Access length encodings on mem_len_i (2'b11 behaves as a word)
  localparam logic [1:0] LEN_BYTE = 2'b00;
  localparam logic [1:0] LEN_HALF = 2'b01;
  localparam logic [1:0] LEN_WORD = 2'b10;

  // Index of the final byte of an access: N-1 for N = 1, 2 or 4
  function automatic logic [1:0] last_byte_idx(input logic [1:0] len);
    case (len)
      LEN_BYTE: return 2'd0;
      LEN_HALF: return 2'd1;
      default:  return 2'd3;
    endcase
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the IF requester, MEM requester and byte-wide RAM port signals.
// slave is the arbiter's view; master is the view of the surrounding pipeline/RAM.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int XLEN   = 32
);

  // Instruction fetch requester
  logic              if_req_i;
  logic [ADDR_W-1:0] if_addr_i;
  logic              if_flush_i;
  logic              if_done_o;
  logic [XLEN-1:0]   if_inst_o;

  // MEM stage requester
  logic              mem_req_i;
  logic              mem_we_i;
  logic [ADDR_W-1:0] mem_addr_i;
  logic [1:0]        mem_len_i;
  logic [XLEN-1:0]   mem_wdata_i;
  logic              mem_done_o;
  logic [XLEN-1:0]   mem_rdata_o;

  // Byte-wide RAM port
  logic [7:0]        ram_din_i;
  logic [7:0]        ram_dout_o;
  logic [ADDR_W-1:0] ram_addr_o;
  logic              ram_wr_o;

  // Stall controller feed
  logic              busy_o;

  modport slave (
    input  if_req_i, if_addr_i, if_flush_i,
    input  mem_req_i, mem_we_i, mem_addr_i, mem_len_i, mem_wdata_i,
    input  ram_din_i,
    output if_done_o, if_inst_o,
    output mem_done_o, mem_rdata_o,
    output ram_dout_o, ram_addr_o, ram_wr_o,
    output busy_o
  );

  modport master (
    output if_req_i, if_addr_i, if_flush_i,
    output mem_req_i, mem_we_i, mem_addr_i, mem_len_i, mem_wdata_i,
    output ram_din_i,
    input  if_done_o, if_inst_o,
    input  mem_done_o, mem_rdata_o,
    input  ram_dout_o, ram_addr_o, ram_wr_o,
    input  busy_o
  );

endinterface

// File: rtl/mem_arbiter.sv
// Shares one byte-wide RAM port between instruction fetch and the MEM stage.
// Each access is split into 1, 2 or 4 consecutive byte transfers; reads are
// reassembled little-endian and handed back with a one-cycle done pulse.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int XLEN   = 32
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  state_e            state_q, state_d;
  owner_e            owner_q;
  logic [1:0]        cnt_q;
  logic [1:0]        last_q;
  logic              we_q;
  logic [ADDR_W-1:0] base_q;
  logic [XLEN-1:0]   wdata_q;
  logic [XLEN-1:0]   data_q;
  logic [XLEN-1:0]   data_next;
  logic [ADDR_W-1:0] addr_hold_q;
  logic [XLEN-1:0]   if_inst_q;
  logic [XLEN-1:0]   mem_rdata_q;

  logic              accept_mem;
  logic              accept_if;
  logic              if_abort;
  logic              cap_en;
  logic [1:0]        cap_idx;
  logic [ADDR_W-1:0] issue_addr;
  logic              write_issue;

  // A flush only matters while the fetch owns the port
  assign if_abort    = (owner_q == OWN_IF) && bus.if_flush_i;
  // Byte address wraps naturally modulo 2^ADDR_W
  assign issue_addr  = base_q + ADDR_W'(cnt_q);
  assign write_issue = (state_q == ST_ISSUE) && we_q;

  // Read bytes arrive one cycle after their address: in ISSUE byte k-1 lands,
  // in DRAIN the final byte lands
  assign cap_en  = !we_q && (((state_q == ST_ISSUE) && (cnt_q != 2'd0)) ||
                             (state_q == ST_DRAIN));
  assign cap_idx = (state_q == ST_DRAIN) ? last_q : (cnt_q - 2'd1);

  // Merge the byte arriving this cycle into the assembly word
  always_comb begin
    data_next = data_q;
    if (cap_en) begin
      data_next[{cap_idx, 3'b000} +: 8] = bus.ram_din_i;
    end
  end

  // Next-state and arbitration: MEM wins, decisions taken only in IDLE
  always_comb begin
    state_d    = state_q;
    accept_mem = 1'b0;
    accept_if  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.mem_req_i) begin
          accept_mem = 1'b1;
          state_d    = ST_ISSUE;
        end else if (bus.if_req_i && !bus.if_flush_i) begin
          accept_if = 1'b1;
          state_d   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (if_abort) begin
          state_d = ST_IDLE;
        end else if (cnt_q == last_q) begin
          state_d = we_q ? ST_DONE : ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        state_d = if_abort ? ST_IDLE : ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control state, byte counter and the values seen by the requesters
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_IF;
      cnt_q       <= 2'd0;
      addr_hold_q <= '0;
      if_inst_q   <= '0;
      mem_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept_mem) begin
        owner_q <= OWN_MEM;
        cnt_q   <= 2'd0;
      end else if (accept_if) begin
        owner_q <= OWN_IF;
        cnt_q   <= 2'd0;
      end else if ((state_q == ST_ISSUE) && (cnt_q != last_q)) begin
        cnt_q <= cnt_q + 2'd1;
      end
      if (state_q == ST_ISSUE) begin
        addr_hold_q <= issue_addr;
      end
      if ((state_q == ST_DRAIN) && (state_d == ST_DONE)) begin
        if (owner_q == OWN_IF) begin
          if_inst_q <= data_next;
        end else begin
          mem_rdata_q <= data_next;
        end
      end
    end
  end

  // Transfer parameters latched at accept; assembly word cleared so unread
  // upper bytes come back as zero
  always_ff @(posedge clk) begin
    if (accept_mem) begin
      base_q  <= bus.mem_addr_i;
      last_q  <= last_byte_idx(bus.mem_len_i);
      we_q    <= bus.mem_we_i;
      wdata_q <= bus.mem_wdata_i;
      data_q  <= '0;
    end else if (accept_if) begin
      base_q  <= bus.if_addr_i;
      last_q  <= last_byte_idx(LEN_WORD);
      we_q    <= 1'b0;
      wdata_q <= '0;
      data_q  <= '0;
    end else begin
      data_q <= data_next;
    end
  end

  assign bus.busy_o      = (state_q != ST_IDLE);
  assign bus.ram_wr_o    = write_issue;
  assign bus.ram_dout_o  = write_issue ? wdata_q[{cnt_q, 3'b000} +: 8] : 8'h00;
  assign bus.ram_addr_o  = (state_q == ST_ISSUE) ? issue_addr : addr_hold_q;
  assign bus.if_done_o   = (state_q == ST_DONE) && (owner_q == OWN_IF) && !bus.if_flush_i;
  assign bus.mem_done_o  = (state_q == ST_DONE) && (owner_q == OWN_MEM);
  assign bus.if_inst_o   = if_inst_q;
  assign bus.mem_rdata_o = mem_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small byte RAM model.
module tb_mem_arbiter;

  localparam int MAXC = 40;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  mem_arbiter_if #(.ADDR_W(32), .XLEN(32)) bus ();

  mem_arbiter #(.ADDR_W(32), .XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: sparse addresses folded into 256 entries; read data one cycle late
  logic [7:0]  ram [256];
  logic        pl_en;
  logic [31:0] pl_addr;
  logic [7:0]  pl_data;

  function automatic int ram_idx(input logic [31:0] a);
    return int'({a[31], a[13], a[12], a[6], a[5], a[2:0]});
  endfunction

  always @(posedge clk) begin
    if (pl_en) ram[ram_idx(pl_addr)] <= pl_data;
    else if (bus.ram_wr_o) ram[ram_idx(bus.ram_addr_o)] <= bus.ram_dout_o;
    bus.ram_din_i <= ram[ram_idx(bus.ram_addr_o)];
  end

  // Per-cycle trace of one scenario
  logic        tr_if_done  [MAXC];
  logic        tr_mem_done [MAXC];
  logic        tr_wr       [MAXC];
  logic        tr_busy     [MAXC];
  logic        tr_allz     [MAXC];
  logic [31:0] tr_addr     [MAXC];
  logic [7:0]  tr_dout     [MAXC];

  task automatic poke(input logic [31:0] a, input logic [7:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  // Runs ncyc cycles from the current one (cycle 0); drops each request after its
  // done pulse; optional flush (with redirect address) and reset injection cycles
  task automatic run(input int ncyc, input int flush_cyc, input logic [31:0] flush_addr,
                     input int rst_cyc);
    for (int c = 0; c < ncyc; c++) begin
      if (c == flush_cyc) begin
        bus.if_flush_i = 1'b1;
        bus.if_addr_i  = flush_addr;
      end
      if (c == rst_cyc) begin
        rst = 1'b1; bus.mem_req_i = 1'b0; bus.if_req_i = 1'b0;
      end
      @(negedge clk);
      tr_if_done[c]  = bus.if_done_o;
      tr_mem_done[c] = bus.mem_done_o;
      tr_wr[c]       = bus.ram_wr_o;
      tr_busy[c]     = bus.busy_o;
      tr_addr[c]     = bus.ram_addr_o;
      tr_dout[c]     = bus.ram_dout_o;
      tr_allz[c]     = ({bus.if_done_o, bus.if_inst_o, bus.mem_done_o, bus.mem_rdata_o,
                         bus.ram_dout_o, bus.ram_addr_o, bus.ram_wr_o, bus.busy_o} == '0);
      @(posedge clk); #1;
      bus.if_flush_i = 1'b0;
      rst = 1'b0;
      if (tr_if_done[c])  bus.if_req_i  = 1'b0;
      if (tr_mem_done[c]) bus.mem_req_i = 1'b0;
    end
  endtask

  function automatic int count_if_done(input int n);
    int k = 0;
    for (int c = 0; c < n; c++) if (tr_if_done[c]) k++;
    return k;
  endfunction

  function automatic int count_mem_done(input int n);
    int k = 0;
    for (int c = 0; c < n; c++) if (tr_mem_done[c]) k++;
    return k;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy_o); end
    checks++; if ({bus.if_done_o, bus.mem_done_o, bus.ram_wr_o} !== 3'b000) begin failures++; $display("FAIL reset_strobes got=%b exp=000", {bus.if_done_o, bus.mem_done_o, bus.ram_wr_o}); end
    checks++; if ({bus.if_inst_o, bus.mem_rdata_o} !== 64'h0) begin failures++; $display("FAIL reset_data got=%h exp=0", {bus.if_inst_o, bus.mem_rdata_o}); end
    checks++; if ({bus.ram_addr_o, bus.ram_dout_o} !== 40'h0) begin failures++; $display("FAIL reset_ram got=%h exp=0", {bus.ram_addr_o, bus.ram_dout_o}); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_fetch();
    bus.if_req_i = 1'b1; bus.if_addr_i = 32'h1000;
    run(10, -1, 32'h0, -1);
    for (int k = 0; k < 4; k++) begin
      checks++; if (tr_addr[1+k] !== 32'h1000 + 32'(k)) begin failures++; $display("FAIL fetch_addr%0d got=%h exp=%h", k, tr_addr[1+k], 32'h1000 + 32'(k)); end
    end
    checks++; if (tr_if_done[6] !== 1'b1 || count_if_done(10) != 1) begin failures++; $display("FAIL fetch_done_cycle got=%b count=%0d exp=1 at cycle 6", tr_if_done[6], count_if_done(10)); end
    checks++; if (bus.if_inst_o !== 32'h0000_0013) begin failures++; $display("FAIL fetch_inst got=%h exp=00000013", bus.if_inst_o); end
    checks++; if ({tr_busy[0], tr_busy[1], tr_busy[6], tr_busy[7]} !== 4'b0110) begin failures++; $display("FAIL fetch_busy got=%b exp=0110", {tr_busy[0], tr_busy[1], tr_busy[6], tr_busy[7]}); end
    checks++; if ({tr_wr[1], tr_wr[2], tr_wr[3], tr_wr[4]} !== 4'b0000) begin failures++; $display("FAIL fetch_wr got=%b exp=0000", {tr_wr[1], tr_wr[2], tr_wr[3], tr_wr[4]}); end
  endtask

  task automatic test_arbitration();
    bus.if_req_i = 1'b1; bus.if_addr_i = 32'h1000;
    bus.mem_req_i = 1'b1; bus.mem_we_i = 1'b0; bus.mem_addr_i = 32'h20; bus.mem_len_i = 2'b10;
    run(16, -1, 32'h0, -1);
    checks++; if (tr_addr[1] !== 32'h20 || tr_addr[4] !== 32'h23) begin failures++; $display("FAIL arb_mem_first got=%h,%h exp=20,23", tr_addr[1], tr_addr[4]); end
    checks++; if (tr_mem_done[6] !== 1'b1 || count_mem_done(16) != 1) begin failures++; $display("FAIL arb_mem_done got=%b count=%0d exp=1 at cycle 6", tr_mem_done[6], count_mem_done(16)); end
    checks++; if (bus.mem_rdata_o !== 32'h4433_2211) begin failures++; $display("FAIL arb_mem_rdata got=%h exp=44332211", bus.mem_rdata_o); end
    checks++; if (tr_busy[7] !== 1'b0 || tr_addr[8] !== 32'h1000) begin failures++; $display("FAIL arb_if_accept got busy7=%b addr8=%h exp 0,00001000", tr_busy[7], tr_addr[8]); end
    checks++; if (tr_if_done[13] !== 1'b1 || count_if_done(16) != 1) begin failures++; $display("FAIL arb_if_done got=%b count=%0d exp=1 at cycle 13", tr_if_done[13], count_if_done(16)); end
  endtask

  task automatic test_store_half();
    bus.mem_req_i = 1'b1; bus.mem_we_i = 1'b1; bus.mem_addr_i = 32'h3;
    bus.mem_len_i = 2'b01; bus.mem_wdata_i = 32'hA5B6_C7D8;
    run(6, -1, 32'h0, -1);
    checks++; if ({tr_wr[0], tr_wr[1], tr_wr[2], tr_wr[3]} !== 4'b0110) begin failures++; $display("FAIL store_wr got=%b exp=0110", {tr_wr[0], tr_wr[1], tr_wr[2], tr_wr[3]}); end
    checks++; if (tr_addr[1] !== 32'h3 || tr_addr[2] !== 32'h4) begin failures++; $display("FAIL store_addr got=%h,%h exp=3,4", tr_addr[1], tr_addr[2]); end
    checks++; if (tr_dout[1] !== 8'hD8 || tr_dout[2] !== 8'hC7) begin failures++; $display("FAIL store_dout got=%h,%h exp=d8,c7", tr_dout[1], tr_dout[2]); end
    checks++; if (tr_mem_done[3] !== 1'b1 || count_mem_done(6) != 1) begin failures++; $display("FAIL store_done got=%b count=%0d exp=1 at cycle 3", tr_mem_done[3], count_mem_done(6)); end
    checks++; if ({ram[ram_idx(32'h3)], ram[ram_idx(32'h4)], ram[ram_idx(32'h5)]} !== 24'hD8C777) begin failures++; $display("FAIL store_ram got=%h exp=d8c777", {ram[ram_idx(32'h3)], ram[ram_idx(32'h4)], ram[ram_idx(32'h5)]}); end
    checks++; if (bus.mem_rdata_o !== 32'h4433_2211) begin failures++; $display("FAIL store_rdata_hold got=%h exp=44332211", bus.mem_rdata_o); end
  endtask

  task automatic test_wrap();
    bus.mem_req_i = 1'b1; bus.mem_we_i = 1'b0; bus.mem_addr_i = 32'hFFFF_FFFF; bus.mem_len_i = 2'b00;
    run(5, -1, 32'h0, -1);
    checks++; if (tr_mem_done[3] !== 1'b1 || count_mem_done(5) != 1) begin failures++; $display("FAIL wrap_byte_done got=%b count=%0d exp=1 at cycle 3", tr_mem_done[3], count_mem_done(5)); end
    checks++; if (bus.mem_rdata_o !== 32'h0000_005A) begin failures++; $display("FAIL wrap_byte_rdata got=%h exp=0000005a", bus.mem_rdata_o); end
    bus.mem_req_i = 1'b1; bus.mem_addr_i = 32'hFFFF_FFFE; bus.mem_len_i = 2'b11;
    run(8, -1, 32'h0, -1);
    checks++; if ({tr_addr[1], tr_addr[2], tr_addr[3], tr_addr[4]} !== 128'hFFFFFFFE_FFFFFFFF_00000000_00000001) begin failures++; $display("FAIL wrap_word_addr got=%h %h %h %h exp=fffffffe ffffffff 0 1", tr_addr[1], tr_addr[2], tr_addr[3], tr_addr[4]); end
    checks++; if (tr_mem_done[6] !== 1'b1) begin failures++; $display("FAIL wrap_word_done got=%b exp=1 at cycle 6", tr_mem_done[6]); end
    checks++; if (bus.mem_rdata_o !== 32'h0201_5A9C) begin failures++; $display("FAIL wrap_word_rdata got=%h exp=02015a9c", bus.mem_rdata_o); end
  endtask

  task automatic test_flush();
    bus.if_req_i = 1'b1; bus.if_addr_i = 32'h1000;
    run(14, 3, 32'h2000, -1);
    checks++; if (tr_busy[4] !== 1'b0) begin failures++; $display("FAIL flush_busy got=%b exp=0", tr_busy[4]); end
    checks++; if (tr_addr[5] !== 32'h2000) begin failures++; $display("FAIL flush_redirect_addr got=%h exp=00002000", tr_addr[5]); end
    checks++; if (tr_if_done[10] !== 1'b1 || count_if_done(14) != 1) begin failures++; $display("FAIL flush_done got=%b count=%0d exp=1 at cycle 10", tr_if_done[10], count_if_done(14)); end
    checks++; if (bus.if_inst_o !== 32'hDEAD_BEEF) begin failures++; $display("FAIL flush_inst got=%h exp=deadbeef", bus.if_inst_o); end
    // Flush while idle delays acceptance by one cycle
    bus.if_req_i = 1'b1; bus.if_addr_i = 32'h1000;
    run(10, 0, 32'h1000, -1);
    checks++; if (tr_busy[1] !== 1'b0 || tr_addr[2] !== 32'h1000) begin failures++; $display("FAIL flush_idle_accept got busy1=%b addr2=%h exp 0,00001000", tr_busy[1], tr_addr[2]); end
    checks++; if (tr_if_done[7] !== 1'b1 || count_if_done(10) != 1) begin failures++; $display("FAIL flush_idle_done got=%b count=%0d exp=1 at cycle 7", tr_if_done[7], count_if_done(10)); end
  endtask

  task automatic test_reset_mid_store();
    bus.mem_req_i = 1'b1; bus.mem_we_i = 1'b1; bus.mem_addr_i = 32'h40;
    bus.mem_len_i = 2'b10; bus.mem_wdata_i = 32'h1122_3344;
    run(5, -1, 32'h0, 2);
    checks++; if (tr_allz[3] !== 1'b1 || tr_busy[3] !== 1'b0) begin failures++; $display("FAIL rst_outputs got allzero=%b busy=%b exp 1,0", tr_allz[3], tr_busy[3]); end
    checks++; if (count_mem_done(5) != 0) begin failures++; $display("FAIL rst_no_done got=%0d exp=0", count_mem_done(5)); end
    checks++; if ({ram[ram_idx(32'h40)], ram[ram_idx(32'h41)], ram[ram_idx(32'h42)]} !== 24'h4433AA) begin failures++; $display("FAIL rst_partial_write got=%h exp=4433aa", {ram[ram_idx(32'h40)], ram[ram_idx(32'h41)], ram[ram_idx(32'h42)]}); end
    bus.mem_req_i = 1'b1; bus.mem_we_i = 1'b0; bus.mem_addr_i = 32'h40; bus.mem_len_i = 2'b10;
    run(8, -1, 32'h0, -1);
    checks++; if (tr_mem_done[6] !== 1'b1 || count_mem_done(8) != 1) begin failures++; $display("FAIL rst_load_done got=%b count=%0d exp=1 at cycle 6", tr_mem_done[6], count_mem_done(8)); end
    checks++; if (bus.mem_rdata_o !== 32'hBBAA_3344) begin failures++; $display("FAIL rst_load_rdata got=%h exp=bbaa3344", bus.mem_rdata_o); end
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    bus.if_req_i = 1'b0; bus.if_addr_i = '0; bus.if_flush_i = 1'b0;
    bus.mem_req_i = 1'b0; bus.mem_we_i = 1'b0; bus.mem_addr_i = '0;
    bus.mem_len_i = 2'b00; bus.mem_wdata_i = '0;
    test_reset();
    poke(32'h1000, 8'h13); poke(32'h1001, 8'h00); poke(32'h1002, 8'h00); poke(32'h1003, 8'h00);
    poke(32'h20, 8'h11);   poke(32'h21, 8'h22);   poke(32'h22, 8'h33);   poke(32'h23, 8'h44);
    poke(32'h3, 8'h00);    poke(32'h4, 8'h00);    poke(32'h5, 8'h77);
    poke(32'hFFFF_FFFE, 8'h9C); poke(32'hFFFF_FFFF, 8'h5A); poke(32'h0, 8'h01); poke(32'h1, 8'h02);
    poke(32'h2000, 8'hEF); poke(32'h2001, 8'hBE); poke(32'h2002, 8'hAD); poke(32'h2003, 8'hDE);
    poke(32'h40, 8'h00);   poke(32'h41, 8'h00);   poke(32'h42, 8'hAA);   poke(32'h43, 8'hBB);
    test_fetch();
    test_arbitration();
    test_store_half();
    test_wrap();
    test_flush();
    test_reset_mid_store();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single byte-wide RAM port between instruction fetch (IF) and the MEM stage.
- Sequences each 32-bit or narrower access as consecutive byte transfers.
- Returns assembled read data and a one-cycle done pulse to the requester.
- Sits between pc_reg/if stage, mem stage and the RAM; busy_o feeds the stall controller.

Parameters:
- ADDR_W, 32, byte-address width of RAM port and both requesters.
- XLEN, 32, data word width (4 bytes).

Ports:
- clk  in  1  clock
- rst  in  1  reset
- if_req_i  in  1  IF fetch request, held until if_done_o or flush
- if_addr_i  in  ADDR_W  fetch address
- if_flush_i  in  1  branch/jump redirect; kills pending or active fetch
- if_done_o  out  1  one-cycle pulse, if_inst_o valid
- if_inst_o  out  XLEN  fetched instruction, little-endian
- mem_req_i  in  1  MEM stage request, held until mem_done_o
- mem_we_i  in  1  1 = store, 0 = load
- mem_addr_i  in  ADDR_W  byte address
- mem_len_i  in  2  00 byte, 01 half, 10 word, 11 treated as word
- mem_wdata_i  in  XLEN  store data, byte 0 = bits 7:0
- mem_done_o  out  1  one-cycle completion pulse
- mem_rdata_o  out  XLEN  load data, zero-extended; sign extension is MEM stage's job
- ram_din_i  in  8  RAM read byte, valid one cycle after its address
- ram_dout_o  out  8  RAM write byte
- ram_addr_o  out  ADDR_W  RAM byte address
- ram_wr_o  out  1  RAM write strobe
- busy_o  out  1  high in every non-IDLE state

Behaviour:
- Reset is synchronous, active-high, on clk; rst forces IDLE at the edge from any state.
- Reset values: all outputs 0.
- A store interrupted by reset is left partially written; this is accepted.
- States:
  - IDLE: sample requests.
  - ISSUE: drive byte k, k = 0..N-1.
  - DRAIN: read only; capture the last byte.
  - DONE: pulse done.
- N = 1, 2 or 4 from mem_len_i; IF is always N = 4.
- Arbitration is sampled only in IDLE:
  - mem_req_i beats if_req_i.
  - No preemption once a transfer leaves IDLE.
  - Base address, length, we and wdata are latched at the accept edge.
- ISSUE cycle k:
  - ram_addr_o = base + k, modulo 2^ADDR_W; wrap past top of memory is allowed.
  - Misaligned addresses are legal.
- Write: ram_wr_o = 1 and ram_dout_o = wdata[8k+7:8k] in each ISSUE cycle. After byte N-1 go to DONE; no DRAIN.
- Read:
  - ram_wr_o = 0.
  - Byte k is captured from ram_din_i in the cycle after its issue, into data[8k+7:8k].
  - Unread upper bytes are 0.
- Latency, with the accept cycle = 0:
  - Read done pulses in cycle N+2 (word 6, half 4, byte 3).
  - Write done pulses in cycle N+1 (word 5).
- DONE lasts exactly one cycle, then IDLE.
- Data outputs hold their value until the next completion of the same requester.
- Requester handshake: update req on the edge ending the done cycle. The following IDLE cycle samples the new value, so back-to-back requests cost one IDLE cycle.
- if_flush_i rules:
  - In IDLE: if_req_i is not accepted that cycle, even if mem_req_i is absent.
  - During an IF transfer (ISSUE/DRAIN): abort, IDLE at the next edge, no if_done_o, ram_wr_o stays 0.
  - In an IF DONE cycle: if_done_o is gated to 0.
  - During a MEM transfer: ignored.
- ram_addr_o holds its last value in IDLE/DONE; ram_wr_o is 0 outside write ISSUE cycles.

Decomposition:
- Length encodings (LEN_BYTE/HALF/WORD) and state encodings go in defines.vh next to StallBus/ZeroWord.
- Single module, one FSM, a 2-bit byte counter and a shift/assemble register; no sub-module is warranted.

Test Plan:
- IF fetch from 0x1000, RAM bytes 13 00 00 00 -> addresses 0x1000..0x1003 in cycles 1-4, if_done_o in cycle 6, if_inst_o = 0x00000013.
- Simultaneous if_req_i and mem_req_i (load word at 0x20) in IDLE -> MEM served first (mem_done_o cycle 6), IF accepted cycle 7, if_done_o cycle 13.
- Store half 0xA5B6C7D8 to 0x3 -> ram_wr_o high cycles 1-2, writes D8@0x3 and C7@0x4, mem_done_o cycle 3, RAM byte 0x5 unchanged.
- Load byte at 0xFFFFFFFF, then load word at 0xFFFFFFFE -> byte read returns 0x000000xx; word issues 0xFFFFFFFE, 0xFFFFFFFF, 0x0, 0x1.
- if_flush_i in cycle 3 of a fetch -> no if_done_o, busy_o low cycle 4; new fetch at the target completes normally.
- rst asserted mid-word-store at cycle 2 -> next cycle all outputs 0 and busy_o 0; subsequent load completes with correct latency.
